// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one combinational signed multiplier between two
// valid/ready requesters, with the operands and the product registered around the multiplier.

module signed_multi #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  output logic [2*WIDTH-1:0] result_out
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH + 1;

  function automatic int rows_at(input int s);
    int n;
    n = ROWS;
    for (int k = 0; k < s; k++) begin
      if (n > 2) n = 2 * (n / 3) + n % 3;
    end
    return n;
  endfunction

  function automatic int stage_count();
    int n;
    int s;
    n = ROWS;
    s = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      s++;
    end
    return s;
  endfunction

  localparam int STAGES = stage_count();

  logic [PW-1:0] a_ext;
  logic [PW-1:0] tree [0:STAGES][0:ROWS-1];

  assign a_ext = {{WIDTH{ina[WIDTH-1]}}, ina};

  // The MSB of inb carries negative weight: its row is inverted and the +1 of the
  // two's-complement negation is added as one extra row.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_pp
    assign tree[0][i] = inb[i] ? (a_ext << i) : '0;
  end
  assign tree[0][WIDTH-1] = inb[WIDTH-1] ? ~(a_ext << (WIDTH - 1)) : '0;
  assign tree[0][WIDTH]   = {{(PW-1){1'b0}}, inb[WIDTH-1]};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int N  = rows_at(s);
    localparam int G  = N / 3;
    localparam int L  = N % 3;
    localparam int NN = 2 * G + L;

    for (genvar g = 0; g < G; g++) begin : g_csa
      assign tree[s+1][2*g]   = tree[s][3*g] ^ tree[s][3*g+1] ^ tree[s][3*g+2];
      assign tree[s+1][2*g+1] = ((tree[s][3*g]   & tree[s][3*g+1]) |
                                 (tree[s][3*g]   & tree[s][3*g+2]) |
                                 (tree[s][3*g+1] & tree[s][3*g+2])) << 1;
    end

    for (genvar j = 0; j < L; j++) begin : g_pass
      assign tree[s+1][2*G+j] = tree[s][3*G+j];
    end

    for (genvar k = NN; k < ROWS; k++) begin : g_zero
      assign tree[s+1][k] = '0;
    end
  end

  assign result_out = tree[STAGES][0] + tree[STAGES][1];

endmodule

module mul_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               res0_valid,
  input  logic               res0_ready,
  output logic [2*WIDTH-1:0] res0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               res1_valid,
  input  logic               res1_ready,
  output logic [2*WIDTH-1:0] res1_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_out;
  logic               owner;
  logic               rr_ptr;
  logic               any_req;
  logic               grant;
  logic               owner_ready;

  assign any_req     = req0_valid | req1_valid;
  assign grant       = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
  assign owner_ready = owner ? res1_ready : res0_ready;

  // Ready is gated by rst_n so nothing is acknowledged while the block is held in reset.
  assign req0_ready = rst_n & (state == IDLE) & any_req & ~grant;
  assign req1_ready = rst_n & (state == IDLE) & any_req & grant;

  assign res0_data = res0_valid ? prod : '0;
  assign res1_data = res1_valid ? prod : '0;

  signed_multi #(.WIDTH(WIDTH)) u_mul (
    .ina        (op_a),
    .inb        (op_b),
    .result_out (mul_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      prod       <= '0;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a  <= grant ? req1_a : req0_a;
            op_b  <= grant ? req1_b : req0_b;
            owner <= grant;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          prod       <= mul_out;
          res0_valid <= ~owner;
          res1_valid <= owner;
          state      <= DONE;
        end
        DONE: begin
          // Fairness pointer only moves on completion, so a stalled result keeps its turn.
          if (owner_ready) begin
            rr_ptr     <= ~owner;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          res0_valid <= 1'b0;
          res1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
